// File: rtl/sync_debounce.sv
// Debouncer for an already-synchronized level: a change is accepted only after
// StableCycles consecutive differing samples, with registered rise/fall pulses.
// Optional: define SYNC_DEBOUNCE_GLITCH_CNT_EN to add a saturating abort counter.
module sync_debounce #(
  parameter int unsigned StableCycles = 4,
  parameter logic        ResetValue   = 1'b0,
  parameter int unsigned CntWidth     = $clog2(StableCycles) + 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        serial_i,
  output logic        level_o,
  output logic        rise_o,
  output logic        fall_o,
  output logic        busy_o
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [15:0] glitch_cnt_o
`endif
);

  typedef enum logic {
    STABLE  = 1'b0,
    QUALIFY = 1'b1
  } state_e;

  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(StableCycles - 1);

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                level_q, level_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;

  // NOTE: every signal gets its default before any branch, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d = STABLE;
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (clr_i) begin
      level_d = ResetValue;
    end else if (serial_i == level_q) begin
      // Bounce back to the current level: abandon qualification silently.
      state_d = STABLE;
    end else if (cnt_q == LastCnt) begin
      level_d = serial_i;
      rise_d  = serial_i;
      fall_d  = ~serial_i;
    end else begin
      cnt_d   = cnt_q + 1'b1;
      state_d = QUALIFY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      level_q <= ResetValue;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign busy_o  = (state_q == QUALIFY);

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  logic [15:0] glitch_cnt_q, glitch_cnt_d;
  logic        abort;

  assign abort = (state_q == QUALIFY) && (serial_i == level_q);

  always_comb begin
    glitch_cnt_d = glitch_cnt_q;
    if (clr_i) begin
      glitch_cnt_d = '0;
    end else if (abort && (glitch_cnt_q != 16'hFFFF)) begin
      glitch_cnt_d = glitch_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      glitch_cnt_q <= '0;
    end else begin
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign glitch_cnt_o = glitch_cnt_q;
`endif

endmodule

// File: tb/tb_sync_debounce.sv
// Scoreboard bench for sync_debounce: a behavioural model pushes expected
// outputs per driven cycle; each test pops and compares after the edge.
module tb_sync_debounce;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst, clr, serial, serial1;
  logic level, rise, fall, busy;
  logic level1, rise1, fall1, busy1;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  logic [15:0] glitch, glitch1;
`endif

  always #5 clk = ~clk;

  sync_debounce #(.StableCycles(N), .ResetValue(1'b0)) dut (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .serial_i(serial),
    .level_o(level), .rise_o(rise), .fall_o(fall), .busy_o(busy)
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    , .glitch_cnt_o(glitch)
`endif
  );

  sync_debounce #(.StableCycles(1), .ResetValue(1'b0)) dut1 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr), .serial_i(serial1),
    .level_o(level1), .rise_o(rise1), .fall_o(fall1), .busy_o(busy1)
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    , .glitch_cnt_o(glitch1)
`endif
  );

  typedef struct packed {
    logic [3:0]  v4;      // {level, rise, fall, busy}
    logic [15:0] glitch;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int errors = 0;
  int checks = 0;

  // Behavioural model: counts the run of samples that disagree with the level.
  logic m_level;
  int   m_run;
  int   m_glitch;
  bit   m_qual;

  function automatic logic [3:0] obs4();
    return {level, rise, fall, busy};
  endfunction

  task automatic model_reset();
    m_level  = 1'b0;
    m_run    = 0;
    m_glitch = 0;
    m_qual   = 1'b0;
  endtask

  // Drive one sample (and clear), push the model's expectation, advance one edge.
  task automatic drive(input logic s, input logic c);
    exp_t x;
    logic r, f;
    serial = s;
    clr    = c;
    r = 1'b0;
    f = 1'b0;
    if (c) begin
      model_reset();
    end else if (s == m_level) begin
      if (m_qual && m_glitch < 65535) m_glitch++;
      m_qual = 1'b0;
      m_run  = 0;
    end else begin
      m_run++;
      if (m_run >= N) begin
        m_level = s;
        m_run   = 0;
        m_qual  = 1'b0;
        r = s;
        f = ~s;
      end else begin
        m_qual = 1'b1;
      end
    end
    x.v4     = {m_level, r, f, m_qual};
    x.glitch = 16'(m_glitch);
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; serial = 1'b1; serial1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (obs4() !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: got %b want 0000", i, obs4());
      end
    end
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (obs4() !== e.v4) begin
        errors++;
        $display("FAIL reset_release cyc%0d: got %b want %b", i, obs4(), e.v4);
      end
      checks++;
      if (rise !== (i == 3)) begin
        errors++;
        $display("FAIL reset_rise_edge cyc%0d: got %b want %b", i, rise, (i == 3));
      end
    end
  endtask

  task automatic test_fall();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (obs4() !== e.v4) begin
        errors++;
        $display("FAIL fall cyc%0d: got %b want %b", i, obs4(), e.v4);
      end
      checks++;
      if (fall !== (i == 3) || level !== (i < 3)) begin
        errors++;
        $display("FAIL fall_edge cyc%0d: got fall=%b level=%b", i, fall, level);
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] pat = 4'b0111;  // bit i is the sample at step i
    for (int i = 0; i < 6; i++) begin
      drive((i < 4) ? pat[i] : 1'b0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (obs4() !== e.v4) begin
        errors++;
        $display("FAIL bounce cyc%0d: got %b want %b", i, obs4(), e.v4);
      end
      checks++;
      if (busy !== (i < 3) || rise !== 1'b0 || level !== 1'b0) begin
        errors++;
        $display("FAIL bounce_direct cyc%0d: got busy=%b rise=%b level=%b", i, busy, rise, level);
      end
    end
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    checks++;
    if (glitch !== 16'd1 || glitch !== e.glitch) begin
      errors++;
      $display("FAIL bounce_glitch_cnt: got %0d want 1 (model %0d)", glitch, e.glitch);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int last_pulse = -100;
    for (int i = 0; i < 12; i++) begin
      drive((i < 4) ? 1'b1 : ((i < 8) ? 1'b0 : 1'b1), 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (obs4() !== e.v4) begin
        errors++;
        $display("FAIL back_to_back cyc%0d: got %b want %b", i, obs4(), e.v4);
      end
      if (rise || fall) begin
        checks++;
        if (i - last_pulse < N) begin
          errors++;
          $display("FAIL pulse_spacing cyc%0d: got %0d want >=%0d", i, i - last_pulse, N);
        end
        last_pulse = i;
        pulses++;
      end
    end
    checks++;
    if (pulses !== 3) begin
      errors++;
      $display("FAIL back_to_back_pulses: got %0d want 3", pulses);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (obs4() !== e.v4) begin
        errors++;
        $display("FAIL pre_reset cyc%0d: got %b want %b", i, obs4(), e.v4);
      end
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (obs4() !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset_immediate: got %b want 0000", obs4());
    end
    @(posedge clk); #1;
    checks++;
    if (obs4() !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset_no_pulse: got %b want 0000", obs4());
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_clear();
    for (int i = 0; i < 5; i++) begin
      drive(i < 4, i == 3);
      e = exp_q.pop_front();
      checks++;
      if (obs4() !== e.v4) begin
        errors++;
        $display("FAIL clear cyc%0d: got %b want %b", i, obs4(), e.v4);
      end
    end
    checks++;
    if (level !== 1'b0 || rise !== 1'b0) begin
      errors++;
      $display("FAIL clear_no_pulse: got level=%b rise=%b want 0 0", level, rise);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 40; r++) begin
      logic v = 1'($urandom_range(0, 1));
      int len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        drive(v, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if (obs4() !== e.v4) begin
          errors++;
          $display("FAIL random run%0d step%0d: got %b want %b", r, i, obs4(), e.v4);
        end
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
        if (glitch !== e.glitch) begin
          errors++;
          $display("FAIL random_glitch run%0d: got %0d want %0d", r, glitch, e.glitch);
        end
`endif
      end
    end
  endtask

  task automatic test_single_cycle();
    logic prev = level1;
    logic s;
    logic [3:0] want;
    for (int i = 0; i < 8; i++) begin
      s = ~i[0];
      serial1 = s;
      want = {s, s & ~prev, ~s & prev, 1'b0};
      @(posedge clk); #1;
      checks++;
      if ({level1, rise1, fall1, busy1} !== want) begin
        errors++;
        $display("FAIL single_cycle cyc%0d: got %b want %b", i,
                 {level1, rise1, fall1, busy1}, want);
      end
      prev = s;
    end
  endtask

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
`ifdef TB_GLITCH_SATURATION
  task automatic test_saturation();
    drive(1'b0, 1'b1);
    void'(exp_q.pop_front());
    for (int i = 0; i < 65537; i++) begin
      drive(1'b1, 1'b0);
      void'(exp_q.pop_front());
      drive(1'b0, 1'b0);
      e = exp_q.pop_front();
    end
    checks++;
    if (glitch !== 16'hFFFF || e.glitch !== 16'hFFFF) begin
      errors++;
      $display("FAIL glitch_saturation: got %h want ffff", glitch);
    end
  endtask
`endif
`endif

  initial begin
    test_reset();
    test_fall();
    test_bounce();
    test_back_to_back();
    test_async_reset();
    test_clear();
    test_random();
    test_single_cycle();
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
`ifdef TB_GLITCH_SATURATION
    test_saturation();
`endif
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
